dmem_responder: RTL and testbench

- Memory-side responder for the core's load/store datapath.
- Accepts one word-aligned request at a time, carrying byte-enabled write data and a byte address, over a valid/ready request channel.
- Commits legal writes into an internal word array. Returns a full 32-bit word, or an error, on a valid/ready response channel after a fixed latency.
- Byte/halfword extraction and sign extension stay on the core side; this block only stores and returns whole words.

---
 rtl/dmem_responder.sv | 118 +++++++++++
 tb/tb_dmem_responder.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding, fixed-latency word memory responder
// with byte-enabled stores and request legality checking.
`default_nettype none

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int RSP_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [2:0] CNT_LOAD = 3'(RSP_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state;
  logic [2:0]              cnt;
  logic [31:0]             hold_data;
  logic                    hold_err;
  logic [31:0]             mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   word_idx;
  logic                    range_err;
  logic                    be_err;
  logic                    req_err;
  logic                    accept;
  logic                    commit;

  wire unused_addr_lsbs = &{1'b0, req_addr[1:0]};

  always_comb begin
    word_idx  = req_addr[ADDR_WIDTH+1:2];
    range_err = (req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
    // Only naturally aligned byte, halfword and word lane patterns are legal.
    case (req_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_err = 1'b0;
      default:                   be_err = 1'b1;
    endcase
    req_err = range_err | (req_write & be_err);
    accept  = (state == IDLE) & req_ready & req_valid;
    commit  = accept & req_write & ~req_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cnt       <= 3'd0;
      hold_data <= 32'd0;
      hold_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= WAIT;
            req_ready <= 1'b0;
            cnt       <= CNT_LOAD;
            hold_data <= (req_write || req_err) ? 32'd0 : mem[word_idx];
            hold_err  <= req_err;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= hold_data;
            rsp_err   <= hold_err;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array is deliberately outside the reset domain; contents survive rst_n.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (req_be[i]) mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of dmem_responder at latency 2 and 1.
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;
  logic        req_valid, req_write, rsp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        ready0, ready1, valid0, valid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic        req_valid0, req_valid1;

  assign req_valid0 = req_valid & ~sel;
  assign req_valid1 = req_valid & sel;

  logic        ready_s, valid_s, err_s;
  logic [31:0] rdata_s;
  assign ready_s = sel ? ready1 : ready0;
  assign valid_s = sel ? valid1 : valid0;
  assign err_s   = sel ? err1   : err0;
  assign rdata_s = sel ? rdata1 : rdata0;

  dmem_responder #(.ADDR_WIDTH(10), .RSP_LATENCY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(ready0), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid0), .rsp_ready(rsp_ready), .rsp_rdata(rdata0), .rsp_err(err0)
  );

  dmem_responder #(.ADDR_WIDTH(10), .RSP_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(valid1), .rsp_ready(rsp_ready), .rsp_rdata(rdata1), .rsp_err(err1)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One request/response transaction; lat counts edges from acceptance to rsp_valid.
  task automatic xact(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, input logic [31:0] exp_rd,
                      output int lat, output logic [31:0] rd, output logic er);
    int n;
    lat = 0; rd = 32'd0; er = 1'b0;
    req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_s && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!valid_s && lat < 20);
    if (!valid_s) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    rd = rdata_s;
    er = err_s;
    if (hold > 0) begin
      rsp_ready = 1'b0;
      repeat (hold) begin
        @(posedge clk);
        #1;
        check("stall_valid", 32'(valid_s), 32'd1);
        check("stall_rdata", rdata_s, exp_rd);
        check("stall_req_ready", 32'(ready_s), 32'd0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check("post_hs_req_ready", 32'(ready_s), 32'd1);
    check("post_hs_rsp_valid", 32'(valid_s), 32'd0);
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic        r;
  int          cyc;
  int          acc[$];

  initial begin
    rst_n = 1'b0; sel = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0;
    req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; req_be = 4'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(ready0), 32'd0);
    check("rst_rsp_valid", 32'(valid0), 32'd0);
    check("rst_rsp_rdata", rdata0, 32'd0);
    check("rst_rsp_err", 32'(err0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 check("rel_req_ready", 32'(ready0), 32'd1);

    // Word write then read
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'd0, lat, rd, er);
    check("t1_wr_lat", 32'(lat), 32'd2);
    check("t1_wr_err", 32'(er), 32'd0);
    check("t1_wr_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t1_rd_lat", 32'(lat), 32'd2);
    check("t1_rd_err", 32'(er), 32'd0);
    check("t1_rd_rdata", rd, 32'hDEADBEEF);

    // Partial lanes
    xact(1'b1, 32'h20, 32'h11223344, 4'b1111, 0, 32'd0, lat, rd, er);
    check("t2_pre_err", 32'(er), 32'd0);
    xact(1'b1, 32'h22, 32'hAAAAAAAA, 4'b0100, 0, 32'd0, lat, rd, er);
    check("t2_sb_err", 32'(er), 32'd0);
    xact(1'b0, 32'h20, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t2_sb_rd", rd, 32'h11AA3344);
    xact(1'b1, 32'h22, 32'hBBCCBBCC, 4'b1100, 0, 32'd0, lat, rd, er);
    check("t2_sh_err", 32'(er), 32'd0);
    xact(1'b0, 32'h20, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t2_sh_rd", rd, 32'hBBCC3344);

    // Errors
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0110, 0, 32'd0, lat, rd, er);
    check("t3_be0110_err", 32'(er), 32'd1);
    check("t3_be0110_rdata", rd, 32'd0);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t3_be0000_err", 32'(er), 32'd1);
    xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0111, 0, 32'd0, lat, rd, er);
    check("t3_be0111_err", 32'(er), 32'd1);
    xact(1'b0, 32'h20, 32'd0, 4'b0110, 0, 32'd0, lat, rd, er);
    check("t3_unchanged_err", 32'(er), 32'd0);
    check("t3_unchanged_rd", rd, 32'hBBCC3344);
    xact(1'b0, 32'h1000, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t3_range_rd_err", 32'(er), 32'd1);
    check("t3_range_rd_rdata", rd, 32'd0);
    xact(1'b1, 32'h1010, 32'h0BADF00D, 4'b1111, 0, 32'd0, lat, rd, er);
    check("t3_range_wr_err", 32'(er), 32'd1);
    xact(1'b0, 32'h10, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t3_no_alias_rd", rd, 32'hDEADBEEF);

    // Backpressure
    xact(1'b0, 32'h10, 32'd0, 4'b0000, 5, 32'hDEADBEEF, lat, rd, er);
    check("t4_rdata", rd, 32'hDEADBEEF);
    check("t4_err", 32'(er), 32'd0);

    // Reset while the write's response is pending in WAIT
    req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'b1111;
    req_valid = 1'b1;
    @(negedge clk);
    check("t5_ready_pre", 32'(ready0), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t5_ready_in_rst", 32'(ready0), 32'd0);
    check("t5_valid_in_rst", 32'(valid0), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check("t5_ready_after", 32'(ready0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("t5_no_rsp", 32'(valid0), 32'd0);
    end
    xact(1'b0, 32'h30, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t5_rd", rd, 32'h12345678);
    check("t5_rd_err", 32'(er), 32'd0);

    // Latency-1 instance
    sel = 1'b1;
    xact(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 0, 32'd0, lat, rd, er);
    check("t6_wr_lat", 32'(lat), 32'd1);
    xact(1'b0, 32'h40, 32'd0, 4'b0000, 0, 32'd0, lat, rd, er);
    check("t6_rd_lat", 32'(lat), 32'd1);
    check("t6_rd", rd, 32'hCAFEF00D);

    // Continuous requests: accept, response, handshake, then the next accept.
    req_write = 1'b0; req_addr = 32'h40; req_valid = 1'b1;
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      r = ready_s;
      if (valid_s) check("t6_b2b_rdata", rdata_s, 32'hCAFEF00D);
      @(posedge clk);
      cyc++;
      if (r) acc.push_back(cyc);
    end
    #1 req_valid = 1'b0;
    check("t6_b2b_count", 32'(acc.size()), 32'd4);
    for (int i = 1; i < acc.size(); i++)
      check("t6_b2b_spacing", 32'(acc[i] - acc[i-1]), 32'd3);
    repeat (3) @(posedge clk);
    #1 check("t6_drain_ready", 32'(ready_s), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
